keypad_matrix_scanner: RTL and testbench

// Parametrised matrix-keypad scanner: drives one active-low column at a time, samples active-low rows,

---
 rtl/keypad_matrix_scanner.sv | 184 ++++++++++++++++++
 tb/tb_keypad_matrix_scanner.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_matrix_scanner.sv
// Matrix keypad scanner: column drive, per-key debounce with n-key
// rollover, one-shot layers and a small event FIFO with valid/ready.
module keypad_matrix_scanner #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SCAN_DIV   = 256,
  parameter int DEBOUNCE   = 3,
  parameter int LAYERS     = 2,
  parameter int FIFO_DEPTH = 4,
  localparam int LW = (LAYERS > 1) ? $clog2(LAYERS) : 1,
  localparam int NK = ROWS * COLS,
  localparam int KW = (NK > 1) ? $clog2(NK) : 1,
  localparam int EW = 1 + LW + KW
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [ROWS-1:0] rows,
  output logic [COLS-1:0] columns,
  input  logic            layer_key,
  output logic [LW-1:0]   layer,
  output logic            ev_valid,
  input  logic            ev_ready,
  output logic [EW-1:0]   ev_data,
  output logic            overflow,
  input  logic            ovf_clear
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {DWELL, PROCESS} state_e;

  state_e          state_q;
  logic [DW-1:0]   div_q;
  logic [CW-1:0]   col_q;
  logic [CW-1:0]   col_d;
  logic [RW-1:0]   r_q;
  logic [COLS-1:0] columns_q;
  logic [ROWS-1:0] rs1_q, rs2_q, snap_q;
  logic            lk1_q, lk2_q, lk3_q;
  logic [LW-1:0]   layer_q;
  logic [LW-1:0]   layer_d;
  logic            ovf_q;

  logic [NK-1:0]   stable_q;
  logic [3:0]      cnt_q  [NK];
  logic [LW-1:0]   play_q [NK];

  logic [EW-1:0]   mem_q  [FIFO_DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [AW:0]     fcnt_q;
  logic [AW:0]     fcnt_d;

  logic [KW-1:0]   key;
  logic            hit, flip, rel, full, pop, wr, drop, lk_edge;
  logic [LW-1:0]   ev_lay;
  logic [EW-1:0]   ev_new;

  assign key     = KW'(KW'(col_q) * KW'(ROWS) + KW'(r_q));
  assign lk_edge = lk2_q & ~lk3_q;

  always_comb begin
    hit    = (state_q == PROCESS) && (snap_q[r_q] != stable_q[key]);
    flip   = hit && ((cnt_q[key] + 4'd1) == 4'(DEBOUNCE));
    rel    = stable_q[key];
    ev_lay = rel ? play_q[key] : layer_q;
    ev_new = {rel, ev_lay, key};
    full   = fcnt_q == (AW+1)'(FIFO_DEPTH);
    pop    = (fcnt_q != '0) && ev_ready;
    wr     = flip && (!full || pop);
    drop   = flip && full && !pop;
    col_d  = (col_q == CW'(COLS-1)) ? '0 : col_q + CW'(1);
  end

  // A press, even a dropped one, consumes the one-shot layer.
  always_comb begin
    layer_d = layer_q;
    if (flip && !rel)
      layer_d = '0;
    else if (lk_edge)
      layer_d = (layer_q == LW'(LAYERS-1)) ? '0 : layer_q + LW'(1);
  end

  always_comb begin
    fcnt_d = fcnt_q;
    unique case (1'b1)
      wr && !pop: fcnt_d = fcnt_q + (AW+1)'(1);
      pop && !wr: fcnt_d = fcnt_q - (AW+1)'(1);
      default:    fcnt_d = fcnt_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= DWELL;
      div_q     <= '0;
      col_q     <= '0;
      r_q       <= '0;
      columns_q <= ~COLS'(1);
      rs1_q     <= '1;
      rs2_q     <= '1;
      snap_q    <= '0;
      lk1_q     <= 1'b0;
      lk2_q     <= 1'b0;
      lk3_q     <= 1'b0;
      layer_q   <= '0;
      ovf_q     <= 1'b0;
      stable_q  <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      fcnt_q    <= '0;
      for (int i = 0; i < NK; i++) begin
        cnt_q[i]  <= '0;
        play_q[i] <= '0;
      end
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      rs1_q <= rows;
      rs2_q <= rs1_q;
      lk1_q <= layer_key;
      lk2_q <= lk1_q;
      lk3_q <= lk2_q;

      unique case (state_q)
        DWELL: begin
          if (div_q == DW'(SCAN_DIV-1)) begin
            snap_q  <= ~rs2_q;
            r_q     <= '0;
            state_q <= PROCESS;
          end else begin
            div_q <= div_q + DW'(1);
          end
        end
        PROCESS: begin
          if (flip) begin
            stable_q[key] <= ~stable_q[key];
            cnt_q[key]    <= '0;
            if (!rel)
              play_q[key] <= layer_q;
          end else if (hit) begin
            cnt_q[key] <= cnt_q[key] + 4'd1;
          end else begin
            cnt_q[key] <= '0;
          end
          if (r_q == RW'(ROWS-1)) begin
            col_q     <= col_d;
            columns_q <= ~(COLS'(1) << col_d);
            div_q     <= '0;
            state_q   <= DWELL;
          end else begin
            r_q <= r_q + RW'(1);
          end
        end
        default: state_q <= DWELL;
      endcase

      layer_q <= layer_d;

      // Full with a same-cycle pop reuses the slot being vacated.
      if (wr) begin
        mem_q[wptr_q] <= ev_new;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (pop)
        rptr_q <= rptr_q + AW'(1);
      fcnt_q <= fcnt_d;

      if (drop)
        ovf_q <= 1'b1;
      else if (ovf_clear)
        ovf_q <= 1'b0;
    end
  end

  assign columns  = columns_q;
  assign layer    = layer_q;
  assign ev_valid = fcnt_q != '0;
  assign ev_data  = mem_q[rptr_q];
  assign overflow = ovf_q;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Directed bench for keypad_matrix_scanner at default parameters,
// with a behavioural 4x4 key matrix.
module tb_keypad_matrix_scanner;

  localparam int FR = 4 * (256 + 4);

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] rows;
  logic [3:0] columns;
  logic       layer_key = 1'b0;
  logic [0:0] layer;
  logic       ev_valid;
  logic       ev_ready = 1'b1;
  logic [5:0] ev_data;
  logic       overflow;
  logic       ovf_clear = 1'b0;

  logic [15:0] kp = '0;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [5:0] evq[$];
  int evc[$];

  keypad_matrix_scanner dut (
    .clock(clock),
    .reset_n(reset_n),
    .rows(rows),
    .columns(columns),
    .layer_key(layer_key),
    .layer(layer),
    .ev_valid(ev_valid),
    .ev_ready(ev_ready),
    .ev_data(ev_data),
    .overflow(overflow),
    .ovf_clear(ovf_clear)
  );

  always #10 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always_comb begin
    rows = '1;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!columns[c] && kp[c*4+r])
          rows[r] = 1'b0;
  end

  always @(negedge clock)
    if (reset_n && ev_valid && ev_ready) begin
      evq.push_back(ev_data);
      evc.push_back(cyc);
    end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] qget(input int i);
    return (evq.size() > i) ? 32'(evq[i]) : 32'hFFFF;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic frames(input int n);
    step(n * FR + 20);
  endtask

  task automatic pulse_layer();
    layer_key = 1'b1;
    step(6);
    layer_key = 1'b0;
    step(6);
  endtask

  initial begin
    logic [3:0] pc;
    int k;

    step(3);
    chk("rst_cols", columns, 4'b1110);
    chk("rst_layer", layer, 0);
    chk("rst_valid", ev_valid, 0);
    chk("rst_data", ev_data, 0);
    chk("rst_ovf", overflow, 0);
    reset_n = 1'b1;
    step(2);

    // single press / release of key 5
    kp[5] = 1'b1;
    frames(4);
    chk("t1_pn", evq.size(), 1);
    chk("t1_pd", qget(0), 6'b0_0_0101);
    kp[5] = 1'b0;
    frames(4);
    chk("t1_rn", evq.size(), 2);
    chk("t1_rd", qget(1), 6'b1_0_0101);
    evq.delete();
    evc.delete();

    // two-frame bounce never reaches the debounce count
    kp[5] = 1'b1;
    step(2 * FR);
    kp[5] = 1'b0;
    frames(2);
    chk("t2_n", evq.size(), 0);
    chk("t2_cnt", dut.cnt_q[5], 0);

    // keys 4 and 6 share column 1: rows 0 and 2 of one pass
    kp[4] = 1'b1;
    kp[6] = 1'b1;
    frames(4);
    chk("t3_n", evq.size(), 2);
    chk("t3_k4", qget(0), 6'd4);
    chk("t3_k6", qget(1), 6'd6);
    chk("t3_gap", (evc.size() == 2) ? evc[1] - evc[0] : -1, 2);
    kp[4] = 1'b0;
    kp[6] = 1'b0;
    frames(4);
    chk("t3_rn", evq.size(), 4);
    evq.delete();
    evc.delete();

    // layer one-shot on key 12
    pulse_layer();
    chk("t4_l1", layer, 1);
    kp[12] = 1'b1;
    frames(4);
    chk("t4_pd", qget(0), 6'b0_1_1100);
    chk("t4_l0", layer, 0);
    pulse_layer();
    chk("t4_l1b", layer, 1);
    kp[12] = 1'b0;
    frames(4);
    chk("t4_rd", qget(1), 6'b1_1_1100);
    chk("t4_n", evq.size(), 2);
    chk("t4_lkeep", layer, 1);
    pulse_layer();
    chk("t4_wrap", layer, 0);
    evq.delete();
    evc.delete();

    // fill the FIFO with the consumer stalled, then overflow it
    ev_ready = 1'b0;
    kp[1] = 1'b1;
    kp[2] = 1'b1;
    kp[3] = 1'b1;
    frames(4);
    kp[7] = 1'b1;
    frames(4);
    kp[8] = 1'b1;
    kp[9] = 1'b1;
    frames(4);
    chk("t5_valid", ev_valid, 1);
    chk("t5_head", ev_data, 6'd1);
    chk("t5_ovf", overflow, 1);
    ev_ready = 1'b1;
    step(10);
    chk("t5_n", evq.size(), 4);
    chk("t5_e0", qget(0), 6'd1);
    chk("t5_e1", qget(1), 6'd2);
    chk("t5_e2", qget(2), 6'd3);
    chk("t5_e3", qget(3), 6'd7);
    chk("t5_ovfh", overflow, 1);
    ovf_clear = 1'b1;
    step(1);
    ovf_clear = 1'b0;
    step(1);
    chk("t5_clr", overflow, 0);
    evq.delete();
    evc.delete();
    kp = '0;
    frames(4);
    chk("t5_rel", evq.size(), 6);
    evq.delete();
    evc.delete();

    // asynchronous reset in the middle of a PROCESS pass
    ev_ready = 1'b0;
    kp[13] = 1'b1;
    kp[14] = 1'b1;
    frames(4);
    pulse_layer();
    chk("t6_valid", ev_valid, 1);
    chk("t6_layer", layer, 1);
    pc = columns;
    for (k = 0; k < 2000; k++) begin
      step(1);
      if (columns != pc) break;
    end
    chk("t6_colchg", k < 2000, 1);
    step(258);
    reset_n = 1'b0;
    #2;
    chk("t6_rvalid", ev_valid, 0);
    chk("t6_rcols", columns, 4'b1110);
    chk("t6_rlayer", layer, 0);
    chk("t6_rdata", ev_data, 0);
    step(2);
    reset_n = 1'b1;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
